// File: rtl/bp_fe_bp_update_queue.sv
// In-order queue of outstanding gshare predictions; pops the head on resolve and issues a
// one-cycle training update. Optional saturating counters enabled by BP_FE_UPDQ_STATS_EN.
module bp_fe_bp_update_queue #(
  parameter int unsigned bht_idx_width_p = 8,
  parameter int unsigned els_p           = 8,
  parameter int unsigned stat_width_p    = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         enq_v_i,
  input  logic [bht_idx_width_p-1:0]   enq_idx_i,
  input  logic                         enq_pred_i,
  output logic                         enq_ready_o,
  input  logic                         res_v_i,
  input  logic                         res_taken_i,
  input  logic                         flush_i,
  output logic                         w_v_o,
  output logic [bht_idx_width_p-1:0]   idx_w_o,
  output logic                         correct_o,
  output logic                         empty_o,
  output logic [$clog2(els_p):0]       count_o
`ifdef BP_FE_UPDQ_STATS_EN
  ,
  output logic [stat_width_p-1:0]      stat_total_o,
  output logic [stat_width_p-1:0]      stat_miss_o
`endif
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);
  localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

  logic [bht_idx_width_p-1:0] idx_mem  [els_p];
  logic                       pred_mem [els_p];

  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    enq_fire, res_fire;

  // Ready and empty come straight from registered occupancy
  assign enq_ready_o = (count_r != cnt_width_lp'(els_p));
  assign empty_o     = (count_r == '0);
  assign count_o     = count_r;

  assign enq_fire = enq_v_i & enq_ready_o & ~flush_i;
  assign res_fire = res_v_i & (count_r != '0);

  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      idx_mem[wr_ptr_r]  <= enq_idx_i;
      pred_mem[wr_ptr_r] <= enq_pred_i;
    end
  end

  // Flush squashes everything left after this cycle's pop
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= '0;
    end else begin
      if (enq_fire) wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
      if (res_fire) rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
      count_r <= count_r + cnt_width_lp'(enq_fire) - cnt_width_lp'(res_fire);
    end
  end

  // Training update; index and direction hold between pulses
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_v_o     <= 1'b0;
      idx_w_o   <= '0;
      correct_o <= 1'b0;
    end else begin
      w_v_o <= res_fire;
      if (res_fire) begin
        idx_w_o   <= idx_mem[rd_ptr_r];
        correct_o <= (pred_mem[rd_ptr_r] == res_taken_i);
      end
    end
  end

`ifdef BP_FE_UPDQ_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_total_o <= '0;
      stat_miss_o  <= '0;
    end else if (w_v_o) begin
      if (stat_total_o != '1) stat_total_o <= stat_total_o + stat_width_p'(1);
      if (!correct_o && (stat_miss_o != '1)) stat_miss_o <= stat_miss_o + stat_width_p'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed bench for bp_fe_bp_update_queue: queue-based reference model checked every cycle
// plus literal spot checks. Define BP_FE_UPDQ_STATS_EN to cover the statistics counters.
module tb_bp_fe_bp_update_queue;

  logic       clk_i, reset_i;
  logic       enq_v_i, enq_pred_i, res_v_i, res_taken_i, flush_i;
  logic [7:0] enq_idx_i;
  logic       enq_ready_o, w_v_o, correct_o, empty_o;
  logic [7:0] idx_w_o;
  logic [3:0] count_o;
`ifdef BP_FE_UPDQ_STATS_EN
  logic [15:0] stat_total_o, stat_miss_o;
`endif

  int checks = 0;
  int failures = 0;

  bp_fe_bp_update_queue #(.bht_idx_width_p(8), .els_p(8), .stat_width_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .enq_v_i(enq_v_i), .enq_idx_i(enq_idx_i), .enq_pred_i(enq_pred_i),
    .enq_ready_o(enq_ready_o),
    .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i),
    .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
    .empty_o(empty_o), .count_o(count_o)
`ifdef BP_FE_UPDQ_STATS_EN
    , .stat_total_o(stat_total_o), .stat_miss_o(stat_miss_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of outstanding predictions
  typedef struct { logic [7:0] idx; logic pred; } entry_t;
  entry_t     mq[$];
  logic       exp_w_v, exp_correct;
  logic [7:0] exp_idx;
  int         exp_total, exp_miss;
  logic       check_en;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mq.delete();
      exp_w_v = 0; exp_idx = 0; exp_correct = 0;
      exp_total = 0; exp_miss = 0;
    end else begin
      automatic bit was_ready = (mq.size() != 8);
      automatic entry_t e;
      if (exp_w_v) begin
        if (exp_total != 16'hffff) exp_total++;
        if (!exp_correct && exp_miss != 16'hffff) exp_miss++;
      end
      exp_w_v = 0;
      if (res_v_i && mq.size() > 0) begin
        e = mq.pop_front();
        exp_w_v = 1; exp_idx = e.idx; exp_correct = (e.pred == res_taken_i);
      end
      if (flush_i) mq.delete();
      else if (enq_v_i && was_ready) begin
        e.idx = enq_idx_i; e.pred = enq_pred_i;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk_i) begin
    if (!reset_i && check_en) begin
      chk("m_count",   32'(count_o),     32'(mq.size()));
      chk("m_empty",   32'(empty_o),     32'(mq.size() == 0));
      chk("m_ready",   32'(enq_ready_o), 32'(mq.size() != 8));
      chk("m_w_v",     32'(w_v_o),       32'(exp_w_v));
      chk("m_idx_w",   32'(idx_w_o),     32'(exp_idx));
      chk("m_correct", 32'(correct_o),   32'(exp_correct));
`ifdef BP_FE_UPDQ_STATS_EN
      chk("m_total",   32'(stat_total_o), 32'(exp_total));
      chk("m_miss",    32'(stat_miss_o),  32'(exp_miss));
`endif
    end
  end

  task automatic step(input logic ev, input logic [7:0] ix, input logic pd,
                      input logic rv, input logic tk, input logic fl);
    enq_v_i = ev; enq_idx_i = ix; enq_pred_i = pd;
    res_v_i = rv; res_taken_i = tk; flush_i = fl;
    @(negedge clk_i);
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    check_en = 0;
    reset_i = 1;
    enq_v_i = 0; enq_idx_i = 0; enq_pred_i = 0; res_v_i = 0; res_taken_i = 0; flush_i = 0;
    repeat (2) @(negedge clk_i);
    reset_i = 0;
    check_en = 1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_ready", 32'(enq_ready_o), 1);
    chk("rst_w_v",   32'(w_v_o), 0);

    // Basic enqueue and in-order resolve
    step(1, 8'h11, 1, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0, 0);
    step(1, 8'h33, 1, 0, 0, 0);
    chk("enq3_count", 32'(count_o), 3);
    chk("enq3_empty", 32'(empty_o), 0);
    step(0, 8'h00, 0, 1, 1, 0);
    chk("res1", {w_v_o, idx_w_o, correct_o}, {1'b1, 8'h11, 1'b1});
    step(0, 8'h00, 0, 1, 1, 0);
    chk("res2", {w_v_o, idx_w_o, correct_o}, {1'b1, 8'h22, 1'b0});
    step(0, 8'h00, 0, 1, 0, 0);
    chk("res3", {w_v_o, idx_w_o, correct_o}, {1'b1, 8'h33, 1'b0});
    idle();
    chk("res_done_w_v",  32'(w_v_o), 0);
    chk("res_done_hold", 32'(idx_w_o), 32'h33);
    chk("res_done_cnt",  32'(count_o), 0);

    // Two more correct updates: 5 issued, 2 mispredicted
    step(1, 8'h44, 1, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 1, 0);
    step(0, 8'h00, 0, 1, 0, 0);
    idle();
`ifdef BP_FE_UPDQ_STATS_EN
    chk("stat_total", 32'(stat_total_o), 5);
    chk("stat_miss",  32'(stat_miss_o), 2);
`endif

    // Fill to full, overflow dropped, resolve+enqueue while full
    for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 1'(i), 0, 0, 0);
    chk("full_ready", 32'(enq_ready_o), 0);
    chk("full_count", 32'(count_o), 8);
    step(1, 8'h99, 0, 0, 0, 0);
    chk("drop_count", 32'(count_o), 8);
    step(1, 8'h9A, 0, 1, 1, 0);
    chk("fullres_count", 32'(count_o), 7);
    chk("fullres_ready", 32'(enq_ready_o), 1);
    chk("fullres_idx",   32'(idx_w_o), 32'h80);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 0, 1, 1'(i + 1), 0);
    chk("drain_idx",   32'(idx_w_o), 32'h87);
    chk("drain_count", 32'(count_o), 0);

    // Resolve plus enqueue on empty: no bypass
    step(1, 8'h5C, 1, 1, 1, 0);
    chk("empty_bypass_w_v", 32'(w_v_o), 0);
    chk("empty_bypass_cnt", 32'(count_o), 1);
    step(0, 8'h00, 0, 1, 1, 0);
    chk("empty_bypass_pop", {w_v_o, idx_w_o, correct_o}, {1'b1, 8'h5C, 1'b1});

    // Flush with same-cycle resolve and dropped enqueue
    for (int i = 0; i < 4; i++) step(1, 8'(8'h61 + i), 0, 0, 0, 0);
    step(1, 8'hEE, 1, 1, 0, 1);
    chk("flush_upd",   {w_v_o, idx_w_o, correct_o}, {1'b1, 8'h61, 1'b1});
    chk("flush_count", 32'(count_o), 0);
    step(0, 8'h00, 0, 1, 1, 0);
    chk("postflush_w_v", 32'(w_v_o), 0);
    step(1, 8'h70, 1, 0, 0, 0);
    step(0, 8'h00, 0, 1, 1, 0);
    chk("postflush_pop", {w_v_o, idx_w_o}, {1'b1, 8'h70});

    // Wrap-around through depth 8 with alternating indices
    for (int i = 0; i < 20; i++)
      step(1, ((i % 2) != 0) ? 8'(8'hA0 + i) : 8'(8'h50 + i), 1'(i >> 1), (i >= 3), 1'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);
    chk("wrap_last_idx", 32'(idx_w_o), 32'hA0 + 19);
    step(0, 8'h00, 0, 1, 1, 0);
    chk("res_empty_w_v", 32'(w_v_o), 0);

    // Asynchronous reset between clock edges
    step(1, 8'h01, 1, 0, 0, 0);
    step(1, 8'h02, 1, 0, 0, 0);
    res_v_i = 1; res_taken_i = 0; enq_v_i = 0;
    @(posedge clk_i);
    #2;
    check_en = 0;
    reset_i = 1;
    #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_empty", 32'(empty_o), 1);
    chk("arst_ready", 32'(enq_ready_o), 1);
    chk("arst_out",   {w_v_o, idx_w_o, correct_o}, 10'h0);
`ifdef BP_FE_UPDQ_STATS_EN
    chk("arst_stats", {stat_total_o, stat_miss_o}, 32'h0);
`endif
    res_v_i = 0;
    @(negedge clk_i);
    reset_i = 0;
    check_en = 1;
    step(0, 8'h00, 0, 1, 1, 0);
    chk("arst_res_ignored", 32'(w_v_o), 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
